stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
- Control and sequencing block for the stopwatch.
- Consumes the 10 ms `tick` pulse and the display-scan pulse produced by the clock divider.
- Runs a start/stop/clear state machine and a 4-digit BCD time counter (SS.CC, 00.00–99.99).
- Time-multiplexes the four digits onto one shared seven-segment BCD bus plus anode selects.

Parameters:
- AN_ACTIVE_LOW, 1, 1 = anode selects active-low (board default); 0 = active-high.
- DP_DIGIT, 2, digit index (0 = rightmost) whose decimal point is lit; separates seconds from hundredths.
- ONE_HOT_SCAN, 1, 1 = anode output is one-hot per digit; 0 = all four anodes enabled simultaneously (test only).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high; sampled on posedge clk.
- tick  input  1  single-cycle pulse every 10 ms, from the divider.
- scan_tick  input  1  single-cycle pulse at the display refresh rate.
- btn_ss  input  1  start/stop button; debounced and synchronised level.
- btn_clr  input  1  clear button; debounced and synchronised level.
- btn_lap  input  1  lap button; debounced level; used only when LAP_HOLD_EN is defined.
- running  output  1  high while in RUN.
- ovf  output  1  sticky; set on wrap from 99.99 to 00.00.
- bcd  output  4  BCD value of the currently scanned digit.
- an  output  4  anode selects, polarity per AN_ACTIVE_LOW.
- dp  output  1  decimal point for the scanned digit, active-high.
- time_bcd  output  16  {sec_tens, sec_ones, hund_tens, hund_ones}, debug/observation.

Behaviour:
- Reset (synchronous, dominates all inputs):
  - state = IDLE; all counters 0; ovf = 0; scan index = 0.
  - running = 0; bcd = 0; dp = 0; an = digit 0 enabled per polarity.
  - Button edge registers cleared.
- Button edges:
  - Each button is registered once; event = level & ~level_q, i.e. a one-cycle pulse on the rising edge.
  - A held button produces exactly one event.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE: counters at 0. ss event -> RUN.
  - RUN: ss event -> PAUSE. clr event -> IDLE.
  - PAUSE: ss event -> RUN. clr event -> IDLE.
  - IDLE + clr event: no change.
- Transition to IDLE clears the counters and ovf on the same edge.
- Simultaneous events:
  - clr and ss events in the same cycle: clr wins.
  - clr and tick in the same cycle: counters become 0; the tick is discarded.
- Counting:
  - Only in RUN, only on cycles where tick = 1; one increment per tick.
  - Digit rollover per increment:
    - hund_ones 9 -> 0, carry to hund_tens.
    - hund_tens 9 -> 0, carry to sec_ones.
    - sec_ones 9 -> 0, carry to sec_tens.
    - sec_tens 9 -> 0, sets ovf; counting continues.
  - No digit ever holds a value above 9.
- Tick timing:
  - A tick arriving in the same cycle as the ss event that enters RUN is not counted; counting starts from the next tick.
  - A tick in the same cycle as the ss event that leaves RUN is counted.
- Scan:
  - On each scan_tick, the scan index advances 0 -> 1 -> 2 -> 3 -> 0.
  - Scanning is independent of FSM state, so the display is always refreshed.
  - bcd, an and dp are registered: they update one clk after the scan index changes.
  - Index 0 = hund_ones … index 3 = sec_tens.
  - dp = 1 only when index == DP_DIGIT.
- running is a registered state decode, so it has the same timing as the state.

Optional Feature:
- Macro: STOPWATCH_LAP_HOLD_EN.
- Defined:
  - A btn_lap event in RUN latches the time into a lap register and sets a display-hold flag.
  - The scanned digits are taken from the lap register while the internal count continues.
  - A second lap event in RUN re-latches the current time (hold stays set).
  - A lap event in PAUSE releases the hold.
  - The hold also releases on a clr event or reset.
  - time_bcd always shows the live count.
- Not defined:
  - btn_lap is ignored and has no edge register.
  - The display always shows the live count.

Test Plan:
- Reset held 3 cycles, then released with no buttons pressed -> state IDLE, time_bcd = 0x0000, running = 0, ovf = 0.
- ss press, then 123 tick pulses -> running = 1, time_bcd = 0x0123; ss press again, then 10 more ticks -> still 0x0123, running = 0.
- Preload to 99.99 via 9999 ticks in RUN, then 1 more tick -> time_bcd = 0x0000, ovf = 1; clr event -> ovf = 0, state IDLE.
- In RUN at 0x0050, drive clr event + ss event + tick in the same cycle -> next cycle state IDLE, time_bcd = 0x0000, running = 0.
- Scan: time 0x1234, pulse scan_tick 4 times -> bcd sequence 4,3,2,1.
  - an = 1110, 1101, 1011, 0111 (active-low).
  - dp = 1 only while bcd = 2.
- With STOPWATCH_LAP_HOLD_EN: lap event at 0x0200, then 100 ticks -> scanned digits still 2,0,0,0, time_bcd = 0x0300.
  - ss event, then lap event -> scanned digits show 0300.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: start/stop/clear FSM, 4-digit BCD time counter (00.00-99.99) and digit scan.
// Optional lap/display-hold feature is enabled by defining STOPWATCH_LAP_HOLD_EN.
module stopwatch_ctrl #(
  parameter bit AN_ACTIVE_LOW = 1'b1,
  parameter int DP_DIGIT      = 2,
  parameter bit ONE_HOT_SCAN  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        scan_tick,
  input  logic        btn_ss,
  input  logic        btn_clr,
  input  logic        btn_lap,
  output logic        running,
  output logic        ovf,
  output logic [3:0]  bcd,
  output logic [3:0]  an,
  output logic        dp,
  output logic [15:0] time_bcd
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic [3:0] AN_RST = AN_ACTIVE_LOW ? 4'b1110 : 4'b0001;

  state_t          state_q;
  logic            running_q;
  logic            ovf_q;
  logic [3:0][3:0] cnt_q;      // [0] = hundredths ones ... [3] = seconds tens
  logic [3:0][3:0] cnt_inc;
  logic            carry;
  logic            btn_ss_q;
  logic            btn_clr_q;
  logic            ss_ev;
  logic            clr_ev;
  logic [3:0][3:0] disp;
  logic [1:0]      scan_idx_q;
  logic [3:0]      bcd_q;
  logic [3:0]      an_q;
  logic [3:0]      an_sel;
  logic            dp_q;

  assign ss_ev  = btn_ss & ~btn_ss_q;
  assign clr_ev = btn_clr & ~btn_clr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_ss_q  <= 1'b0;
      btn_clr_q <= 1'b0;
    end else begin
      btn_ss_q  <= btn_ss;
      btn_clr_q <= btn_clr;
    end
  end

  // Ripple BCD increment; carry out of the top digit marks the 99.99 -> 00.00 wrap.
  always_comb begin
    cnt_inc = cnt_q;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (cnt_q[i] == 4'd9) begin
          cnt_inc[i] = 4'd0;
        end else begin
          cnt_inc[i] = cnt_q[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else if (clr_ev) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      // A tick on the cycle that leaves RUN still counts; one on the entering cycle does not.
      if (state_q == RUN && tick) begin
        cnt_q <= cnt_inc;
        if (carry) ovf_q <= 1'b1;
      end
      case (state_q)
        IDLE: if (ss_ev) begin
          state_q   <= RUN;
          running_q <= 1'b1;
        end
        RUN: if (ss_ev) begin
          state_q   <= PAUSE;
          running_q <= 1'b0;
        end
        PAUSE: if (ss_ev) begin
          state_q   <= RUN;
          running_q <= 1'b1;
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  logic            btn_lap_q;
  logic            lap_ev;
  logic            hold_q;
  logic [3:0][3:0] lap_q;

  assign lap_ev = btn_lap & ~btn_lap_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_lap_q <= 1'b0;
      hold_q    <= 1'b0;
      lap_q     <= '0;
    end else begin
      btn_lap_q <= btn_lap;
      if (clr_ev) begin
        hold_q <= 1'b0;
      end else if (lap_ev && state_q == RUN) begin
        lap_q  <= cnt_q;
        hold_q <= 1'b1;
      end else if (lap_ev && state_q == PAUSE) begin
        hold_q <= 1'b0;
      end
    end
  end

  assign disp = hold_q ? lap_q : cnt_q;
`else
  logic unused_btn_lap;
  assign unused_btn_lap = btn_lap;
  assign disp           = cnt_q;
`endif

  always_comb begin
    an_sel = ONE_HOT_SCAN ? (4'b0001 << scan_idx_q) : 4'b1111;
    if (AN_ACTIVE_LOW) an_sel = ~an_sel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_idx_q <= 2'd0;
      bcd_q      <= 4'd0;
      an_q       <= AN_RST;
      dp_q       <= 1'b0;
    end else begin
      if (scan_tick) scan_idx_q <= scan_idx_q + 2'd1;
      bcd_q <= disp[scan_idx_q];
      an_q  <= an_sel;
      dp_q  <= (32'(scan_idx_q) == DP_DIGIT);
    end
  end

  assign running  = running_q;
  assign ovf      = ovf_q;
  assign bcd      = bcd_q;
  assign an       = an_q;
  assign dp       = dp_q;
  assign time_bcd = cnt_q;

endmodule
